ramreader_stream: RTL and testbench

- Consumer end of the sample ring buffer in on-chip RAM. Tracks the write pulses of the 64-bit RAM writer and reads each written word back in write order.
- Each word is unpacked into four 16-bit samples and presented on a valid/ready stream toward the host link (UART/SPI framer).
- Sits between the RAM read port and the host link. Also reports fill level and a sticky overflow flag.

---
 rtl/ramreader_pkg.sv | 18 +
 rtl/ramreader_stream_word_unpacker.sv | 52 +++++
 rtl/ramreader_stream.sv | 130 +++++++++++++
 tb/tb_ramreader_stream.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ramreader_pkg.sv
// rtl/ramreader_pkg.sv - shared state type, ring constants and pointer helper for ramreader_stream
package ramreader_pkg;

    typedef enum logic [1:0] {IDLE, READ_WAIT, EMIT} state_e;

    localparam int unsigned RING_ADDR_FIRST  = 1;
    localparam int unsigned RING_ADDR_LAST   = 32'h3FFF;
    localparam int unsigned RING_RD_START    = 2;
    localparam int unsigned SAMPLES_PER_WORD = 4;

    // Address 0 is reserved, so the ring wraps back to first rather than to zero.
    function automatic int unsigned wrap_inc(input int unsigned x,
                                             input int unsigned first,
                                             input int unsigned last);
        return (x == last) ? first : x + 1;
    endfunction

endpackage

// File: rtl/ramreader_stream_word_unpacker.sv
// rtl/ramreader_stream_word_unpacker.sv - splits one RAM word into sample lanes, lowest lane first
module word_unpacker #(
    parameter int DATA_W   = 64,
    parameter int SAMPLE_W = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                load_i,
    input  logic [DATA_W-1:0]   word_i,
    input  logic                ready_i,
    output logic [SAMPLE_W-1:0] sample_o,
    output logic                valid_o,
    output logic                done_o
);
    localparam int LANES = DATA_W / SAMPLE_W;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [LANES-1:0][SAMPLE_W-1:0] lanes_q;
    logic [IDX_W-1:0]               idx_q;
    logic [IDX_W-1:0]               idx_next;
    logic [SAMPLE_W-1:0]            sample_q;
    logic                           valid_q;
    logic                           last_lane;

    assign last_lane = (idx_q == IDX_W'(LANES - 1));
    assign idx_next  = idx_q + IDX_W'(1);
    assign done_o    = valid_q & ready_i & last_lane;
    assign sample_o  = sample_q;
    assign valid_o   = valid_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            lanes_q  <= '0;
            idx_q    <= '0;
            sample_q <= '0;
            valid_q  <= 1'b0;
        end else if (load_i) begin
            lanes_q  <= word_i;
            idx_q    <= '0;
            sample_q <= word_i[SAMPLE_W-1:0];
            valid_q  <= 1'b1;
        end else if (valid_q && ready_i) begin
            if (last_lane) begin
                valid_q <= 1'b0;
            end else begin
                idx_q    <= idx_next;
                sample_q <= lanes_q[idx_next];
            end
        end
    end

endmodule

// File: rtl/ramreader_stream.sv
// rtl/ramreader_stream.sv - ring-buffer reader: follows writer strobes, reads RAM words, streams samples
module ramreader_stream
    import ramreader_pkg::*;
#(
    parameter int          ADDR_W     = 14,
    parameter int          DATA_W     = 64,
    parameter int          SAMPLE_W   = 16,
    parameter int unsigned ADDR_FIRST = RING_ADDR_FIRST,
    parameter int unsigned ADDR_LAST  = RING_ADDR_LAST,
    parameter int unsigned RD_START   = RING_RD_START,
    parameter int          RD_LATENCY = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_wr_strobe,
    input  logic [ADDR_W-1:0]   i_wr_address,
    output logic [ADDR_W-1:0]   o_rd_address,
    output logic                o_rden,
    input  logic [DATA_W-1:0]   i_rd_data,
    output logic [SAMPLE_W-1:0] o_sample,
    output logic                o_sample_valid,
    input  logic                i_sample_ready,
    output logic [ADDR_W-1:0]   o_level,
    output logic                o_overflow,
    input  logic                i_clear_overflow
);
    localparam int unsigned DEPTH = ADDR_LAST - ADDR_FIRST + 1;
    localparam int          CNT_W = 3;

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rden_q;
    logic [ADDR_W-1:0] rd_addr_q;
    logic [ADDR_W-1:0] rd_ptr_q;
    logic [ADDR_W-1:0] rd_ptr_d;
    logic [ADDR_W-1:0] level_q;
    logic [ADDR_W-1:0] level_d;
    logic              overflow_q;
    logic              issue;
    logic              ovf;
    logic              load;
    logic              done;

    assign load = (state_q == READ_WAIT) && (cnt_q == CNT_W'(RD_LATENCY));

    always_comb begin
        issue    = (state_q == IDLE) && (level_q != '0);
        ovf      = i_wr_strobe && (level_q == ADDR_W'(DEPTH)) && !issue;
        level_d  = level_q;
        rd_ptr_d = rd_ptr_q;
        // On a lap the reader skips to just past the writer; any word in flight still completes.
        if (ovf) begin
            level_d  = '0;
            rd_ptr_d = ADDR_W'(wrap_inc(32'(i_wr_address), ADDR_FIRST, ADDR_LAST));
        end else begin
            if (issue) begin
                rd_ptr_d = ADDR_W'(wrap_inc(32'(rd_ptr_q), ADDR_FIRST, ADDR_LAST));
            end
            if (i_wr_strobe && !issue) begin
                level_d = level_q + ADDR_W'(1);
            end else if (!i_wr_strobe && issue) begin
                level_d = level_q - ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            rden_q     <= 1'b0;
            rd_addr_q  <= ADDR_W'(RD_START);
            rd_ptr_q   <= ADDR_W'(RD_START);
            level_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            rden_q   <= 1'b0;
            level_q  <= level_d;
            rd_ptr_q <= rd_ptr_d;
            if (ovf) begin
                overflow_q <= 1'b1;
            end else if (i_clear_overflow) begin
                overflow_q <= 1'b0;
            end
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        rden_q    <= 1'b1;
                        rd_addr_q <= rd_ptr_q;
                        cnt_q     <= '0;
                        state_q   <= READ_WAIT;
                    end
                end
                READ_WAIT: begin
                    if (load) begin
                        state_q <= EMIT;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                EMIT: begin
                    if (done) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    word_unpacker #(
        .DATA_W   (DATA_W),
        .SAMPLE_W (SAMPLE_W)
    ) u_unpacker (
        .clk_i    (i_clk),
        .rst_i    (i_rst),
        .load_i   (load),
        .word_i   (i_rd_data),
        .ready_i  (i_sample_ready),
        .sample_o (o_sample),
        .valid_o  (o_sample_valid),
        .done_o   (done)
    );

    assign o_rden       = rden_q;
    assign o_rd_address = rd_addr_q;
    assign o_level      = level_q;
    assign o_overflow   = overflow_q;

endmodule

// File: tb/tb_ramreader_stream.sv
// tb/tb_ramreader_stream.sv - scoreboard bench for ramreader_stream
module tb_ramreader_stream;
    localparam int ADDR_W     = 14;
    localparam int DATA_W     = 64;
    localparam int SAMPLE_W   = 16;
    localparam int RD_LATENCY = 2;
    localparam int FULL       = 16383;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic                i_wr_strobe;
    logic [ADDR_W-1:0]   i_wr_address;
    logic [ADDR_W-1:0]   o_rd_address;
    logic                o_rden;
    logic [DATA_W-1:0]   i_rd_data;
    logic [SAMPLE_W-1:0] o_sample;
    logic                o_sample_valid;
    logic                i_sample_ready;
    logic [ADDR_W-1:0]   o_level;
    logic                o_overflow;
    logic                i_clear_overflow;

    always #5 i_clk = ~i_clk;

    ramreader_stream dut (
        .i_clk            (i_clk),
        .i_rst            (i_rst),
        .i_wr_strobe      (i_wr_strobe),
        .i_wr_address     (i_wr_address),
        .o_rd_address     (o_rd_address),
        .o_rden           (o_rden),
        .i_rd_data        (i_rd_data),
        .o_sample         (o_sample),
        .o_sample_valid   (o_sample_valid),
        .i_sample_ready   (i_sample_ready),
        .o_level          (o_level),
        .o_overflow       (o_overflow),
        .i_clear_overflow (i_clear_overflow)
    );

    logic [DATA_W-1:0] mem [int];
    logic [DATA_W-1:0] rd_pipe [RD_LATENCY];

    always @(posedge i_clk) begin
        if (o_rden) begin
            rd_pipe[0] <= mem.exists(int'(o_rd_address)) ? mem[int'(o_rd_address)] : '0;
        end else begin
            rd_pipe[0] <= 64'hDEAD_BEEF_DEAD_BEEF;
        end
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign i_rd_data = rd_pipe[RD_LATENCY-1];

    int tests_run = 0;
    int fails = 0;
    logic [ADDR_W-1:0]   exp_addr_q [$];
    logic [SAMPLE_W-1:0] exp_smp_q [$];
    logic [ADDR_W-1:0]   wr_addr;

    always @(negedge i_clk) begin
        logic [ADDR_W-1:0]   ea;
        logic [SAMPLE_W-1:0] es;
        if (!i_rst) begin
            if (o_rden) begin
                tests_run++;
                if (exp_addr_q.size() == 0) begin
                    fails++;
                    $display("FAIL rd_addr: unexpected read at %h, none expected", o_rd_address);
                end else begin
                    ea = exp_addr_q.pop_front();
                    if (o_rd_address !== ea) begin
                        fails++;
                        $display("FAIL rd_addr: got %h expected %h", o_rd_address, ea);
                    end
                end
                tests_run++;
                if (o_rd_address === '0) begin
                    fails++;
                    $display("FAIL rd_addr_zero: got %h expected nonzero", o_rd_address);
                end
            end
            if (o_sample_valid && i_sample_ready) begin
                tests_run++;
                if (exp_smp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sample: unexpected sample %h", o_sample);
                end else begin
                    es = exp_smp_q.pop_front();
                    if (o_sample !== es) begin
                        fails++;
                        $display("FAIL sample: got %h expected %h", o_sample, es);
                    end
                end
            end
        end
    end

    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return (a == 14'h3FFF) ? 14'h0001 : a + 14'd1;
    endfunction

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic write_word(input logic [DATA_W-1:0] d);
        mem[int'(wr_addr)] = d;
        exp_addr_q.push_back(wr_addr);
        for (int k = 0; k < DATA_W / SAMPLE_W; k++) exp_smp_q.push_back(d[SAMPLE_W*k +: SAMPLE_W]);
        i_wr_strobe  = 1'b1;
        i_wr_address = wr_addr;
        tick();
        i_wr_strobe  = 1'b0;
        wr_addr      = next_addr(wr_addr);
    endtask

    task automatic strobe_only(input logic [ADDR_W-1:0] a, input logic clr);
        i_wr_strobe      = 1'b1;
        i_wr_address     = a;
        i_clear_overflow = clr;
        tick();
        i_wr_strobe      = 1'b0;
        i_clear_overflow = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_addr_q.size() != 0 || exp_smp_q.size() != 0 || o_sample_valid) && n < 400) begin
            tick();
            n++;
        end
        repeat (3) tick();
        tests_run++;
        if (n >= 400) begin
            fails++;
            $display("FAIL %s_drain: %0d addr / %0d samples outstanding, expected 0", name,
                     exp_addr_q.size(), exp_smp_q.size());
        end
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!o_sample_valid && n < 50) begin
            tick();
            n++;
        end
        tests_run++;
        if (!o_sample_valid) begin
            fails++;
            $display("FAIL %s_wait_valid: valid %b expected 1", name, o_sample_valid);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        tests_run += 6;
        if (o_rden !== 1'b0) begin fails++; $display("FAIL %s_rden: got %b expected 0", name, o_rden); end
        if (o_sample_valid !== 1'b0) begin fails++; $display("FAIL %s_valid: got %b expected 0", name, o_sample_valid); end
        if (o_sample !== 16'h0) begin fails++; $display("FAIL %s_sample: got %h expected 0000", name, o_sample); end
        if (o_overflow !== 1'b0) begin fails++; $display("FAIL %s_overflow: got %b expected 0", name, o_overflow); end
        if (o_rd_address !== 14'd2) begin fails++; $display("FAIL %s_rd_address: got %h expected 0002", name, o_rd_address); end
        if (o_level !== 14'd0) begin fails++; $display("FAIL %s_level: got %0d expected 0", name, o_level); end
    endtask

    task automatic test_reset();
        i_rst = 1'b1;
        i_wr_strobe = 1'b0;
        i_wr_address = '0;
        i_sample_ready = 1'b1;
        i_clear_overflow = 1'b0;
        repeat (3) tick();
        i_rst = 1'b0;
        tick();
        check_reset_outputs("reset");
        wr_addr = 14'd2;
    endtask

    task automatic test_single();
        write_word(64'h0007_0006_0005_0004);
        tests_run++;
        if (o_level !== 14'd1) begin fails++; $display("FAIL single_level1: got %0d expected 1", o_level); end
        tick();
        tests_run += 2;
        if (o_rden !== 1'b1) begin fails++; $display("FAIL single_rden: got %b expected 1", o_rden); end
        if (o_level !== 14'd0) begin fails++; $display("FAIL single_level0: got %0d expected 0", o_level); end
        drain("single");
    endtask

    task automatic test_simultaneous();
        write_word({$urandom, $urandom});
        write_word({$urandom, $urandom});
        tests_run += 2;
        if (o_rden !== 1'b1) begin fails++; $display("FAIL simul_rden: got %b expected 1", o_rden); end
        if (o_level !== 14'd1) begin fails++; $display("FAIL simul_level: got %0d expected 1", o_level); end
        drain("simul");
    endtask

    task automatic test_backpressure();
        logic [SAMPLE_W-1:0] held;
        i_sample_ready = 1'b0;
        write_word({$urandom, $urandom});
        wait_valid("bp");
        held = o_sample;
        tests_run++;
        if (held !== exp_smp_q[0]) begin fails++; $display("FAIL bp_first: got %h expected %h", held, exp_smp_q[0]); end
        for (int c = 0; c < 20; c++) begin
            if (c % 4 == 0) write_word({$urandom, $urandom});
            else tick();
            tests_run++;
            if (o_sample !== held || o_sample_valid !== 1'b1) begin
                fails++;
                $display("FAIL bp_hold: got %h/%b expected %h/1", o_sample, o_sample_valid, held);
            end
        end
        tests_run++;
        if (o_level !== 14'd5) begin fails++; $display("FAIL bp_level: got %0d expected 5", o_level); end
        i_sample_ready = 1'b1;
        drain("bp");
    endtask

    task automatic test_reset_mid();
        write_word({$urandom, $urandom});
        tick();
        tick();
        i_rst = 1'b1;
        #1;
        check_reset_outputs("rstmid");
        exp_addr_q.delete();
        exp_smp_q.delete();
        repeat (3) tick();
        i_rst = 1'b0;
        repeat (5) tick();
        tests_run += 2;
        if (o_rden !== 1'b0) begin fails++; $display("FAIL rstmid_idle_rden: got %b expected 0", o_rden); end
        if (o_level !== 14'd0) begin fails++; $display("FAIL rstmid_idle_level: got %0d expected 0", o_level); end
        wr_addr = 14'd2;
        write_word({$urandom, $urandom});
        drain("rstmid");
    endtask

    task automatic fill_to_overflow(input string name, input logic [ADDR_W-1:0] last_a, input logic clr);
        i_sample_ready = 1'b0;
        write_word({$urandom, $urandom});
        wait_valid(name);
        for (int i = 0; i < FULL; i++) begin
            strobe_only(wr_addr, 1'b0);
            wr_addr = next_addr(wr_addr);
        end
        tests_run += 2;
        if (o_level !== 14'(FULL)) begin fails++; $display("FAIL %s_full_level: got %0d expected %0d", name, o_level, FULL); end
        if (o_overflow !== 1'b0) begin fails++; $display("FAIL %s_full_ovf: got %b expected 0", name, o_overflow); end
        strobe_only(last_a, clr);
        tests_run += 2;
        if (o_overflow !== 1'b1) begin fails++; $display("FAIL %s_ovf_set: got %b expected 1", name, o_overflow); end
        if (o_level !== 14'd0) begin fails++; $display("FAIL %s_ovf_level: got %0d expected 0", name, o_level); end
        i_sample_ready = 1'b1;
        drain(name);
        wr_addr = next_addr(last_a);
    endtask

    task automatic test_overflow();
        fill_to_overflow("ovf", 14'h0100, 1'b0);
        i_clear_overflow = 1'b1;
        tick();
        i_clear_overflow = 1'b0;
        tests_run++;
        if (o_overflow !== 1'b0) begin fails++; $display("FAIL ovf_clear: got %b expected 0", o_overflow); end
        tests_run++;
        if (wr_addr !== 14'h0101) begin fails++; $display("FAIL ovf_resync_addr: got %h expected 0101", wr_addr); end
        write_word({$urandom, $urandom});
        drain("ovf_after");
    endtask

    task automatic test_wrap();
        fill_to_overflow("wrap", 14'h3FFD, 1'b1);
        repeat (3) write_word({$urandom, $urandom});
        drain("wrap");
        tests_run++;
        if (wr_addr !== 14'h0002) begin fails++; $display("FAIL wrap_wr_addr: got %h expected 0002", wr_addr); end
        i_clear_overflow = 1'b1;
        tick();
        i_clear_overflow = 1'b0;
        tests_run++;
        if (o_overflow !== 1'b0) begin fails++; $display("FAIL wrap_clear: got %b expected 0", o_overflow); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_simultaneous();
        test_backpressure();
        test_reset_mid();
        test_overflow();
        test_wrap();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule
